nist_test_sequencer: RTL

//  Sequences the NIST statistical test engines (frequency, runs, longest-run-of-ones, ...) on PUF/TRNG output.

---
 rtl/nist_test_sequencer_if.sv | 13 +
 rtl/nist_test_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/nist_test_sequencer_if.sv
// nist_test_sequencer_if: source handshake and engine stream/result bus of the NIST test sequencer.
interface nist_test_sequencer_if #(
    parameter int NUM_TESTS = 3
);
    logic                 src_bit;
    logic                 src_valid;
    logic                 src_ready;
    logic                 eng_rst;
    logic                 eng_bit;
    logic [NUM_TESTS-1:0] eng_pass;
    modport master (input src_bit, src_valid, eng_pass, output src_ready, eng_rst, eng_bit);
    modport slave (output src_bit, src_valid, eng_pass, input src_ready, eng_rst, eng_bit);
endinterface

// File: rtl/nist_test_sequencer.sv
// nist_test_sequencer: buffers one SEQ_LEN-bit sequence and replays it gap-free to the NIST engines for ROUNDS rounds.
// Define SEQ_FAIL_CNT_EN to add saturating per-engine fail counters (fail_cnt).
module nist_test_sequencer #(
    parameter int SEQ_LEN    = 128,
    parameter int NUM_TESTS  = 3,
    parameter int RESULT_LAT = 4,
    parameter int ROUNDS     = 16,
    parameter int ROUND_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    nist_test_sequencer_if.master        bus,
    output logic                         busy,
    output logic                         res_valid,
    output logic [NUM_TESTS-1:0]         res_pass,
    output logic [NUM_TESTS-1:0]         pass_vec,
    output logic [ROUND_W-1:0]           round_cnt,
`ifdef SEQ_FAIL_CNT_EN
    output logic [NUM_TESTS*ROUND_W-1:0] fail_cnt,
`endif
    output logic                         done
);
    localparam int CW = $clog2(SEQ_LEN + RESULT_LAT + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(SEQ_LEN - 1);
    localparam logic [CW-1:0] LAST_LAT = CW'(RESULT_LAT - 1);
    localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(ROUNDS - 1);

    if (ROUNDS < 1 || ROUNDS > 2 ** ROUND_W - 1 || SEQ_LEN < 2 || RESULT_LAT < 1) begin : g_cfg_check
        $error("nist_test_sequencer: illegal ROUNDS/ROUND_W/SEQ_LEN/RESULT_LAT combination");
    end

    typedef enum logic [2:0] {IDLE, FLUSH, FILL, STREAM, SETTLE, SAMPLE, DONE} state_t;

    state_t             state;
    logic [SEQ_LEN-1:0] sbuf;
    logic [CW-1:0]      cnt;

    // sbuf is a shift register: bits enter at the top, so the first accepted bit ends up in sbuf[0]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sbuf          <= '0;
            cnt           <= '0;
            busy          <= 1'b0;
            res_valid     <= 1'b0;
            done          <= 1'b0;
            res_pass      <= '0;
            pass_vec      <= '0;
            round_cnt     <= '0;
            bus.src_ready <= 1'b0;
            bus.eng_rst   <= 1'b1;
            bus.eng_bit   <= 1'b0;
`ifdef SEQ_FAIL_CNT_EN
            fail_cnt      <= '0;
`endif
        end else begin
            res_valid <= 1'b0;
            done      <= 1'b0;
            if (abort) begin
                state         <= IDLE;
                busy          <= 1'b0;
                bus.src_ready <= 1'b0;
                bus.eng_rst   <= 1'b1;
                bus.eng_bit   <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state     <= FLUSH;
                        busy      <= 1'b1;
                        pass_vec  <= '1;
                        round_cnt <= '0;
`ifdef SEQ_FAIL_CNT_EN
                        fail_cnt  <= '0;
`endif
                    end
                    FLUSH: begin
                        cnt           <= '0;
                        state         <= FILL;
                        bus.src_ready <= 1'b1;
                    end
                    FILL: if (bus.src_valid) begin
                        sbuf <= {bus.src_bit, sbuf[SEQ_LEN-1:1]};
                        cnt  <= cnt + 1'b1;
                        // sbuf[1] still holds the first bit until this final shift lands
                        if (cnt == LAST_BIT) begin
                            state         <= STREAM;
                            cnt           <= '0;
                            bus.src_ready <= 1'b0;
                            bus.eng_rst   <= 1'b0;
                            bus.eng_bit   <= sbuf[1];
                        end
                    end
                    STREAM: begin
                        sbuf        <= {sbuf[0], sbuf[SEQ_LEN-1:1]};
                        cnt         <= (cnt == LAST_BIT) ? '0 : cnt + 1'b1;
                        state       <= (cnt == LAST_BIT) ? SETTLE : STREAM;
                        bus.eng_bit <= (cnt == LAST_BIT) ? 1'b0 : sbuf[1];
                    end
                    SETTLE: begin
                        cnt   <= cnt + 1'b1;
                        state <= (cnt == LAST_LAT) ? SAMPLE : SETTLE;
                    end
                    SAMPLE: begin
                        res_pass    <= bus.eng_pass;
                        res_valid   <= 1'b1;
                        pass_vec    <= pass_vec & bus.eng_pass;
                        round_cnt   <= round_cnt + 1'b1;
                        bus.eng_rst <= 1'b1;
                        done        <= (round_cnt == LAST_RND);
                        state       <= (round_cnt == LAST_RND) ? DONE : FLUSH;
`ifdef SEQ_FAIL_CNT_EN
                        for (int t = 0; t < NUM_TESTS; t++)
                            if (!bus.eng_pass[t] && fail_cnt[t*ROUND_W +: ROUND_W] != '1)
                                fail_cnt[t*ROUND_W +: ROUND_W] <= fail_cnt[t*ROUND_W +: ROUND_W] + 1'b1;
`endif
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
